nand_phy_wr_dqs_ctrl: RTL and testbench

- Write-direction strobe and data sequencer for the NAND DDR PHY. It is the transmit counterpart to the DQS/DQ capture path.
- It takes a burst request and data words from the controller. It drives dqs_oe_n, dqs_rst_n, dq_oe_n and the rise/fall data into the DQS/DQ IOBs, generating the ONFI write preamble, toggling burst and postamble.
- It sits between the NAND controller FSM and the PHY IOB instances, entirely in the clk0 domain.

---
 rtl/nand_phy_wr_dqs_ctrl.sv | 147 ++++++++++++++
 tb/tb_nand_phy_wr_dqs_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nand_phy_wr_dqs_ctrl.sv
// NAND DDR PHY write-direction DQS/DQ sequencer.
// Generates the DQS write preamble, the toggling burst and the postamble.
// Delays the rise/fall data and the DQ output enable so they line up with
// the retimed dqs_rst_n inside the DQS IOB.
module nand_phy_wr_dqs_ctrl #(
  parameter int DQ_WIDTH      = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int PREAMBLE_CYC  = 2,
  parameter int POSTAMBLE_CYC = 2,
  parameter int DQ_ALIGN_LAT  = 2
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  wr_start,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  input  logic [2*DQ_WIDTH-1:0] wr_data,
  input  logic                  wr_data_valid,
  output logic                  wr_data_rden,
  output logic                  dqs_oe_n,
  output logic                  dqs_rst_n,
  output logic                  dq_oe_n,
  output logic [DQ_WIDTH-1:0]   dq_rise,
  output logic [DQ_WIDTH-1:0]   dq_fall,
  output logic                  busy,
  output logic                  wr_done
);

  // A zero-length pre/postamble cannot be expressed, so it is clamped to one cycle.
  localparam int PRE_N  = (PREAMBLE_CYC  < 1) ? 1 : PREAMBLE_CYC;
  localparam int POST_N = (POSTAMBLE_CYC < 1) ? 1 : POSTAMBLE_CYC;
  localparam int LAT    = (DQ_ALIGN_LAT  < 1) ? 1 : DQ_ALIGN_LAT;
  localparam int CMAX   = (PRE_N > POST_N) ? PRE_N : POST_N;
  localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
  localparam int WW     = 2 * DQ_WIDTH;

  localparam logic [CW-1:0] PRE_LD  = CW'(PRE_N - 1);
  localparam logic [CW-1:0] POST_LD = CW'(POST_N - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_BURST, S_POST, S_DONE} state_t;

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] word_cnt, word_cnt_nx;
  // PRE and POST never overlap, so one down-counter serves both phases.
  logic [CW-1:0]        ph_cnt, ph_cnt_nx;
  logic                 zlen_done;
  logic                 accept;
  logic                 oe_tag_n;
  logic [WW-1:0]        d_in;
  logic [WW-1:0]        last_word;
  logic [LAT-1:0][WW-1:0] pipe_d;
  logic [LAT-1:0]       pipe_oe_n;

  assign accept       = (state == S_BURST) && wr_data_valid;
  assign wr_data_rden = accept;
  assign busy         = (state != S_IDLE);
  assign wr_done      = (state == S_DONE) || zlen_done;

  // State register and burst/phase counters.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      ph_cnt   <= '0;
    end else begin
      state    <= state_nx;
      word_cnt <= word_cnt_nx;
      ph_cnt   <= ph_cnt_nx;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_nx    = state;
    word_cnt_nx = word_cnt;
    ph_cnt_nx   = ph_cnt;
    case (state)
      S_IDLE: begin
        if (wr_start && (wr_len != '0)) begin
          word_cnt_nx = wr_len;
          ph_cnt_nx   = PRE_LD;
          state_nx    = S_PRE;
        end
      end
      S_PRE: begin
        if (ph_cnt == '0) state_nx  = S_BURST;
        else              ph_cnt_nx = ph_cnt - CW'(1);
      end
      S_BURST: begin
        if (wr_data_valid) begin
          word_cnt_nx = word_cnt - LEN_WIDTH'(1);
          if (word_cnt == LEN_WIDTH'(1)) begin
            state_nx  = S_POST;
            ph_cnt_nx = POST_LD;
          end
        end
      end
      S_POST: begin
        if (ph_cnt == '0) state_nx  = S_DONE;
        else              ph_cnt_nx = ph_cnt - CW'(1);
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // DQS IOB controls, registered one cycle behind the state.
  // dqs_rst_n follows acceptance, so a data underflow parks DQS low.
  // A zero-length request only earns a done pulse on the next cycle.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      dqs_oe_n  <= 1'b1;
      dqs_rst_n <= 1'b0;
      zlen_done <= 1'b0;
    end else begin
      dqs_oe_n  <= !(state inside {S_PRE, S_BURST, S_POST});
      dqs_rst_n <= accept;
      zlen_done <= (state == S_IDLE) && wr_start && (wr_len == '0);
    end
  end

  // Stall bubbles repeat the last accepted word so DQ does not glitch.
  // DQ stays driven through the postamble.
  assign d_in     = accept ? wr_data : last_word;
  assign oe_tag_n = !((state == S_BURST) || (state == S_POST));

  // Alignment pipe: data plus oe tag, delayed to line up with DQS.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      last_word <= '0;
      pipe_d    <= '0;
      pipe_oe_n <= '1;
    end else begin
      last_word    <= d_in;
      pipe_d[0]    <= d_in;
      pipe_oe_n[0] <= oe_tag_n;
      for (int i = 1; i < LAT; i++) begin
        pipe_d[i]    <= pipe_d[i-1];
        pipe_oe_n[i] <= pipe_oe_n[i-1];
      end
    end
  end

  assign dq_rise = pipe_d[LAT-1][DQ_WIDTH-1:0];
  assign dq_fall = pipe_d[LAT-1][WW-1:DQ_WIDTH];
  assign dq_oe_n = pipe_oe_n[LAT-1];

endmodule

// File: tb/tb_nand_phy_wr_dqs_ctrl.sv
// Bench for nand_phy_wr_dqs_ctrl: a schedule-based burst model plus directed literal checks.
module tb_nand_phy_wr_dqs_ctrl;
  localparam int DW   = 8;
  localparam int LW   = 16;
  localparam int PRE  = 2;
  localparam int POST = 2;
  localparam int LAT  = 2;
  localparam int WW   = 2 * DW;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          wr_start;
  logic [LW-1:0] wr_len;
  logic [WW-1:0] wr_data;
  logic          wr_data_valid;
  logic          wr_data_rden, dqs_oe_n, dqs_rst_n, dq_oe_n, busy, wr_done;
  logic [DW-1:0] dq_rise, dq_fall;

  nand_phy_wr_dqs_ctrl #(
    .DQ_WIDTH(DW), .LEN_WIDTH(LW), .PREAMBLE_CYC(PRE),
    .POSTAMBLE_CYC(POST), .DQ_ALIGN_LAT(LAT)
  ) dut (
    .clk0(clk0), .rst0(rst0), .wr_start(wr_start), .wr_len(wr_len),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_rden(wr_data_rden),
    .dqs_oe_n(dqs_oe_n), .dqs_rst_n(dqs_rst_n), .dq_oe_n(dq_oe_n),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .busy(busy), .wr_done(wr_done)
  );

  always #5 clk0 = ~clk0;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_rden, cnt_rst, cnt_done;
  logic chk_en = 1'b0;

  // expected outputs for the current cycle
  logic e_dqs_oe_n, e_dqs_rst_n, e_dq_oe_n, e_rden, e_busy, e_done;
  logic [DW-1:0] e_rise, e_fall;

  // burst schedule: one entry per BURST cycle (valid bit and the word offered)
  int            bv[$];
  logic [WW-1:0] bw[$];
  logic [WW-1:0] prev_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // mode 0: burst per schedule, 1: zero-length request at k=0, 2: idle.
  // Cycle k=0 is the cycle wr_start is presented; PRE occupies 1..PRE,
  // BURST the next bv.size() cycles, then POST cycles, then one DONE cycle.
  function automatic void model(input int mode, input int k);
    int b0, p0, dn, kd;
    logic [WW-1:0] w;
    b0 = PRE + 1;
    p0 = b0 + bv.size();
    dn = p0 + POST;
    kd = k - LAT;
    w  = prev_word;
    e_busy = 0; e_done = 0; e_rden = 0;
    e_dqs_oe_n = 1; e_dqs_rst_n = 0; e_dq_oe_n = 1;
    if (mode == 1) e_done = (k == 1);
    else if (mode == 0) begin
      e_busy      = (k >= 1) && (k <= dn);
      e_done      = (k == dn);
      e_rden      = (k >= b0) && (k < p0) && (bv[k-b0] != 0);
      e_dqs_oe_n  = !((k >= 2) && (k <= dn));
      e_dqs_rst_n = (k - 1 >= b0) && (k - 1 < p0) && (bv[k-1-b0] != 0);
      e_dq_oe_n   = !((kd >= b0) && (kd < dn));
      for (int j = 0; j < bv.size(); j++)
        if (bv[j] != 0 && b0 + j <= kd) w = bw[j];
    end
    {e_fall, e_rise} = w;
  endfunction

  // per-cycle compare against the model
  always @(negedge clk0) begin
    if (chk_en) begin
      chk("dqs_oe_n", 32'(dqs_oe_n), 32'(e_dqs_oe_n));
      chk("dqs_rst_n", 32'(dqs_rst_n), 32'(e_dqs_rst_n));
      chk("dq_oe_n", 32'(dq_oe_n), 32'(e_dq_oe_n));
      chk("dq_rise", 32'(dq_rise), 32'(e_rise));
      chk("dq_fall", 32'(dq_fall), 32'(e_fall));
      chk("wr_data_rden", 32'(wr_data_rden), 32'(e_rden));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("wr_done", 32'(wr_done), 32'(e_done));
      if (wr_data_rden) cnt_rden++;
      if (dqs_rst_n)    cnt_rst++;
      if (wr_done)      cnt_done++;
    end
  end

  task automatic drive_rand_data();
    wr_data_valid = 1'($urandom_range(1));
    wr_data       = WW'($urandom);
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk0); #1;
      rst0 = 0; wr_start = 0; wr_len = LW'($urandom);
      drive_rand_data();
      model(2, k);
      chk_en = 1;
    end
  endtask

  task automatic build_sched(input int len, input int pct, input bit fixed);
    bv.delete(); bw.delete();
    for (int i = 0; i < len; i++) begin
      for (int s = 0; s < 3 && $urandom_range(99) < pct; s++) begin
        bv.push_back(0); bw.push_back(WW'($urandom));
      end
      bv.push_back(1);
      if (fixed) bw.push_back({8'(8'h11 * (2 * i + 1)), 8'(8'h11 * (2 * i))});
      else       bw.push_back(WW'($urandom));
    end
  endtask

  // Drive one burst per the schedule; extra wr_start pulses land in PRE..DONE.
  task automatic run_burst(input int len, input int abort_k, input bit pin4);
    int dn, last, b0;
    bit aborted;
    b0   = PRE + 1;
    dn   = b0 + bv.size() + POST;
    last = (abort_k >= 0) ? abort_k + 4 : dn + LAT + 2;
    aborted = 0;
    cnt_rden = 0; cnt_rst = 0; cnt_done = 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk0); #1;
      rst0 = (abort_k >= 0) && (k == abort_k);
      if (abort_k >= 0 && k == abort_k + 1) begin
        aborted = 1; prev_word = '0;
      end
      wr_start = !aborted && ((k == 0) || (k == 1) || (k == dn) ||
                 ((k >= 1) && (k < dn) && ($urandom_range(3) == 0)));
      wr_len = (k == 0) ? LW'(len) : LW'($urandom);
      if (!aborted && k >= b0 && k < b0 + bv.size()) begin
        wr_data_valid = (bv[k-b0] != 0);
        wr_data       = bw[k-b0];
      end else drive_rand_data();
      model(aborted ? 2 : 0, k);
      chk_en = 1;
      if (pin4 && (k == 5 || k == 8)) begin
        @(negedge clk0); #1;
        chk("pin_rise", 32'(dq_rise), (k == 5) ? 32'h00 : 32'h66);
        chk("pin_fall", 32'(dq_fall), (k == 5) ? 32'h11 : 32'h77);
      end
      if (abort_k >= 0 && k == abort_k + 1) begin
        @(negedge clk0); #1;
        chk("abort_dqs_oe_n", 32'(dqs_oe_n), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
      end
    end
    if (!aborted) prev_word = bw[bv.size()-1];
  endtask

  task automatic run_zero();
    cnt_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk0); #1;
      rst0 = 0; wr_start = (k == 0);
      wr_len = (k == 0) ? '0 : LW'($urandom);
      drive_rand_data();
      model(1, k);
      chk_en = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1; wr_start = 0; wr_len = '0; wr_data = '0; wr_data_valid = 0;
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    chk("rst_dqs_oe_n", 32'(dqs_oe_n), 32'h1);
    chk("rst_dqs_rst_n", 32'(dqs_rst_n), 32'h0);
    chk("rst_dq_oe_n", 32'(dq_oe_n), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    run_idle(10);

    // len 4, valid held high, fixed data pattern
    build_sched(4, 0, 1);
    run_burst(4, -1, 1);
    chk("len4_rden_cnt", 32'(cnt_rden), 32'd4);
    chk("len4_dqsrst_cnt", 32'(cnt_rst), 32'd4);
    chk("len4_done_cnt", 32'(cnt_done), 32'd1);

    // len 3 with a 3-cycle underflow after the first word
    bv.delete(); bw.delete();
    foreach (bv[i]) bv[i] = 0;
    bv.push_back(1); bv.push_back(0); bv.push_back(0);
    bv.push_back(0); bv.push_back(1); bv.push_back(1);
    for (int i = 0; i < 6; i++) bw.push_back(WW'($urandom));
    run_burst(3, -1, 0);
    chk("len3_rden_cnt", 32'(cnt_rden), 32'd3);
    chk("len3_dqsrst_cnt", 32'(cnt_rst), 32'd3);
    chk("len3_done_cnt", 32'(cnt_done), 32'd1);

    run_zero();
    chk("zlen_done_cnt", 32'(cnt_done), 32'd1);

    // reset after 2 of 8 words
    build_sched(8, 0, 0);
    run_burst(8, PRE + 3, 0);
    chk("abort_done_cnt", 32'(cnt_done), 32'd0);
    build_sched(1, 0, 0);
    run_burst(1, -1, 0);
    chk("post_abort_done_cnt", 32'(cnt_done), 32'd1);

    // randomized bursts
    for (int it = 0; it < 30; it++) begin
      int r, len;
      r = $urandom_range(9);
      if (r == 0) run_zero();
      else begin
        len = $urandom_range(10, 1);
        build_sched(len, (r < 5) ? 0 : 35, 0);
        run_burst(len, -1, 0);
        chk("rand_rden_cnt", 32'(cnt_rden), 32'(len));
      end
      run_idle($urandom_range(2));
    end

    @(posedge clk0); #1;
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
